// File: rtl/key_scan8_pkg.sv
// Shared constants and types for the 8-key scan front end.
// Latency: none (types and a combinational helper only).
// Backpressure: none.
package key_pkg;

  localparam int NKEYS        = 8;
  localparam int IDX_W        = 3;
  localparam int DBC_W        = 4;
  localparam int TICK_DIV_DEF = 50000;
  localparam int DB_CNT_DEF   = 4;

  typedef logic [NKEYS-1:0] keyvec_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [DBC_W-1:0] dbc_t;

  // One-hot decode of an encoder index back into a key bit mask.
  function automatic keyvec_t idx_onehot(input idx_t idx);
    idx_onehot = keyvec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/key_scan8_if.sv
// Key scan bundle: raw keys and retire controls in, debounced/pending state out.
// Latency: wiring only.
// Backpressure: none; pending bits are held until explicitly retired.
interface key_scan8_if;
  import key_pkg::*;

  keyvec_t key_raw;
  logic    clr;
  idx_t    clr_idx;
  logic    ovf_clr;
  keyvec_t key_stable;
  keyvec_t key_pend;
  logic    pend_valid;
  logic    ovf;

  // Consumer / stimulus side.
  modport master (
    output key_raw, clr, clr_idx, ovf_clr,
    input  key_stable, key_pend, pend_valid, ovf
  );

  // Scanner side.
  modport slave (
    input  key_raw, clr, clr_idx, ovf_clr,
    output key_stable, key_pend, pend_valid, ovf
  );

endinterface

// File: rtl/key_scan8_db_cell.sv
// Per-key synchroniser, polarity normalise and tick-driven debouncer.
// Latency: 2 clk of sync plus DB_CNT ticks from raw edge to stable.
// Backpressure: none; rise is a single-cycle pulse coincident with the stable update.
module key_db_cell
  import key_pkg::*;
#(
  parameter int DB_CNT     = DB_CNT_DEF,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic stable,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic samp;
  logic hit;
  dbc_t cnt;

  // The sync flops reset to the idle (released) raw level, so the normalised
  // sample reads "not pressed" out of reset; a key held through reset then
  // has to walk the full sync + debounce path again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign samp = sync2 ^ ACTIVE_LOW;

  // This tick is the DB_CNT-th consecutive one with a differing level.
  assign hit = tick && (samp != stable) && (cnt == dbc_t'(DB_CNT - 1));

  // Debounce counter and accepted level, advanced only on sample ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (tick) begin
      if (samp == stable) begin
        cnt <= '0;
      end else if (hit) begin
        cnt    <= '0;
        stable <= ~stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Press event is flagged in the cycle before stable flips, so the pending
  // register captures it on the very same edge.
  assign rise = hit && !stable;

endmodule

// File: rtl/key_scan8.sv
// Eight-key front end: sync/debounce, pending press latch with retire, sticky overflow.
// Latency: 2 clk + DB_CNT ticks raw->key_stable; key_pend updates on the same edge.
// Backpressure: presses stay pending until clr/clr_idx retires them; repeats set ovf.
module key_scan8
  import key_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DB_CNT     = DB_CNT_DEF,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  key_scan8_if.slave        bus
);

  logic    tick;
  keyvec_t stable;
  keyvec_t rise;
  keyvec_t clr_vec;
  keyvec_t pend;
  keyvec_t pend_nxt;
  logic    ovf_hit;
  logic    ovf_q;

  generate
    if (TICK_DIV <= 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      localparam int PW = $clog2(TICK_DIV);
      logic [PW-1:0] div_cnt;

      // Free-running prescaler, wraps at TICK_DIV-1.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div_cnt <= '0;
        end else if (div_cnt == PW'(TICK_DIV - 1)) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      assign tick = (div_cnt == PW'(TICK_DIV - 1));
    end
  endgenerate

  for (genvar g = 0; g < NKEYS; g++) begin : g_cell
    key_db_cell #(
      .DB_CNT     (DB_CNT),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (bus.key_raw[g]),
      .tick   (tick),
      .stable (stable[g]),
      .rise   (rise[g])
    );
  end

  // Retire decode and next pending state; a press racing its own retire wins.
  always_comb begin
    clr_vec  = bus.clr ? idx_onehot(bus.clr_idx) : '0;
    pend_nxt = rise | (pend & ~clr_vec);
    ovf_hit  = |(rise & pend & ~clr_vec);
  end

  // Pending latch and sticky overflow; a fresh overflow beats ovf_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= '0;
      ovf_q <= 1'b0;
    end else begin
      pend  <= pend_nxt;
      ovf_q <= ovf_hit | (ovf_q & ~bus.ovf_clr);
    end
  end

  assign bus.key_stable = stable;
  assign bus.key_pend   = pend;
  assign bus.pend_valid = |pend;
  assign bus.ovf        = ovf_q;

endmodule
